// File: rtl/car_warning_ctrl.sv
// rtl/car_warning_ctrl.sv - debounced door/seat-belt warning controller with timed chime
// Switch inputs are filtered, faults registered, and a 4-state FSM drives the chime.
module car_warning_ctrl #(
  parameter int NUM_DOORS  = 4,
  parameter int NUM_SEATS  = 2,
  parameter int DEBOUNCE   = 3,
  parameter int GRACE_CYC  = 100,
  parameter int CHIME_HALF = 10,
  parameter int CHIME_MAX  = 200
) (
  input  logic                 Clk,
  input  logic                 RstN,
  input  logic                 Ignition,
  input  logic [NUM_DOORS-1:0] DoorClose,
  input  logic [NUM_SEATS-1:0] SeatBelt,
  input  logic [NUM_SEATS-1:0] Occupied,
  input  logic                 Ack,
  output logic                 Alarm,
  output logic                 DoorWarn,
  output logic [NUM_SEATS-1:0] BeltWarn,
  output logic [1:0]           State
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRACE = 2'd1;
  localparam logic [1:0] S_CHIME = 2'd2;
  localparam logic [1:0] S_MUTED = 2'd3;

  localparam int NB = NUM_DOORS + 2 * NUM_SEATS;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int GW = $clog2(GRACE_CYC + 1);
  localparam int CW = $clog2(CHIME_MAX);
  localparam int HW = (CHIME_HALF > 1) ? $clog2(CHIME_HALF) : 1;
  localparam logic [NB-1:0] FILT_RST = {{NUM_SEATS{1'b0}}, {NUM_SEATS{1'b1}}, {NUM_DOORS{1'b1}}};

  logic [NB-1:0]        raw;
  logic [NB-1:0]        filt_d, filt_q;
  logic [DW-1:0]        deb_cnt_d [NB];
  logic [DW-1:0]        deb_cnt_q [NB];
  logic                 door_fault_d, door_fault_q;
  logic [NUM_SEATS-1:0] belt_fault_d, belt_fault_q;
  logic [NUM_SEATS:0]   prev_fault_q;
  logic [1:0]           state_d, state_q;
  logic [GW-1:0]        grace_d, grace_q;
  logic [CW-1:0]        chime_d, chime_q;
  logic [HW-1:0]        half_d, half_q;
  logic                 alarm_d, alarm_q;
  logic                 any_fault, new_fault, enter_chime;

  // Bit layout of the filtered vector: {Occupied, SeatBelt, DoorClose}
  always_comb begin
    raw    = {Occupied, SeatBelt, DoorClose};
    filt_d = filt_q;
    for (int i = 0; i < NB; i++) begin
      deb_cnt_d[i] = '0;
      if (raw[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEBOUNCE - 1)) filt_d[i] = raw[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    door_fault_d = Ignition & ~(&filt_q[NUM_DOORS-1:0]);
    belt_fault_d = {NUM_SEATS{Ignition}} & filt_q[NUM_DOORS+NUM_SEATS +: NUM_SEATS]
                   & ~filt_q[NUM_DOORS +: NUM_SEATS];
  end

  assign any_fault = door_fault_q | (|belt_fault_q);
  assign new_fault = |({door_fault_q, belt_fault_q} & ~prev_fault_q);

  always_comb begin
    state_d     = state_q;
    grace_d     = grace_q;
    chime_d     = chime_q;
    half_d      = half_q;
    alarm_d     = 1'b0;
    enter_chime = 1'b0;
    if (!Ignition) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (door_fault_q) enter_chime = 1'b1;
          else if (|belt_fault_q) begin
            state_d = S_GRACE;
            grace_d = GW'(GRACE_CYC);
          end
        end
        S_GRACE: begin
          if (!any_fault) state_d = S_IDLE;
          else if (door_fault_q || grace_q == GW'(1)) enter_chime = 1'b1;
          else grace_d = grace_q - 1'b1;
        end
        S_CHIME: begin
          if (!any_fault) state_d = S_IDLE;
          else if (Ack || chime_q == CW'(CHIME_MAX - 1)) state_d = S_MUTED;
          else begin
            chime_d = chime_q + 1'b1;
            if (half_q == HW'(CHIME_HALF - 1)) begin
              half_d  = '0;
              alarm_d = ~alarm_q;
            end else begin
              half_d  = half_q + 1'b1;
              alarm_d = alarm_q;
            end
          end
        end
        S_MUTED: begin
          if (!any_fault) state_d = S_IDLE;
          else if (new_fault) enter_chime = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Every CHIME entry restarts the timeout and opens with Alarm high
    if (enter_chime) begin
      state_d = S_CHIME;
      chime_d = '0;
      half_d  = '0;
      alarm_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      filt_q       <= FILT_RST;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= '0;
      door_fault_q <= 1'b0;
      belt_fault_q <= '0;
      prev_fault_q <= '0;
      state_q      <= S_IDLE;
      grace_q      <= '0;
      chime_q      <= '0;
      half_q       <= '0;
      alarm_q      <= 1'b0;
    end else begin
      filt_q       <= filt_d;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      door_fault_q <= door_fault_d;
      belt_fault_q <= belt_fault_d;
      prev_fault_q <= {door_fault_q, belt_fault_q};
      state_q      <= state_d;
      grace_q      <= grace_d;
      chime_q      <= chime_d;
      half_q       <= half_d;
      alarm_q      <= alarm_d;
    end
  end

  assign Alarm    = alarm_q;
  assign DoorWarn = door_fault_q;
  assign BeltWarn = belt_fault_q;
  assign State    = state_q;

endmodule

// File: tb/tb_car_warning_ctrl.sv
// tb/tb_car_warning_ctrl.sv - directed and random checks of car_warning_ctrl against a reference model
module tb_car_warning_ctrl;

  localparam int ND = 4, NS = 2, DEB = 2, GRACE = 8, HALF = 2, CMAX = 16;
  localparam int NB = ND + 2 * NS;
  localparam int M_IDLE = 0, M_GRACE = 1, M_CHIME = 2, M_MUTED = 3;

  logic          Clk = 1'b0, RstN = 1'b0, Ignition = 1'b0, Ack = 1'b0;
  logic [ND-1:0] DoorClose = '1;
  logic [NS-1:0] SeatBelt = '1, Occupied = '0;
  logic          Alarm, DoorWarn;
  logic [NS-1:0] BeltWarn;
  logic [1:0]    State;
  int checks = 0, errors = 0;

  always #5 Clk = ~Clk;

  car_warning_ctrl #(
    .NUM_DOORS(ND), .NUM_SEATS(NS), .DEBOUNCE(DEB),
    .GRACE_CYC(GRACE), .CHIME_HALF(HALF), .CHIME_MAX(CMAX)
  ) dut (
    .Clk(Clk), .RstN(RstN), .Ignition(Ignition), .DoorClose(DoorClose),
    .SeatBelt(SeatBelt), .Occupied(Occupied), .Ack(Ack),
    .Alarm(Alarm), .DoorWarn(DoorWarn), .BeltWarn(BeltWarn), .State(State)
  );

  // Reference model: debounce by a window of recent samples, timers by age in state
  int            m_state, m_age;
  logic          m_alarm, m_door;
  logic [NS-1:0] m_belt;
  logic [NS:0]   m_prev;
  logic [NB-1:0] m_filt;
  logic [NB-1:0] m_hist [DEB];

  task automatic model_reset();
    m_state = M_IDLE; m_age = 0; m_alarm = 1'b0; m_door = 1'b0;
    m_belt = '0; m_prev = '0;
    m_filt = {{NS{1'b0}}, {NS{1'b1}}, {ND{1'b1}}};
    for (int k = 0; k < DEB; k++) m_hist[k] = m_filt;
  endtask

  task automatic model_step();
    logic any, newf;
    int ns;
    logic [NB-1:0] mask;
    any  = m_door | (|m_belt);
    newf = |({m_door, m_belt} & ~m_prev);
    ns = m_state;
    if (!Ignition) ns = M_IDLE;
    else case (m_state)
      M_IDLE:  if (m_door) ns = M_CHIME; else if (|m_belt) ns = M_GRACE;
      M_GRACE: if (!any) ns = M_IDLE; else if (m_door || m_age == GRACE - 1) ns = M_CHIME;
      M_CHIME: if (!any) ns = M_IDLE; else if (Ack || m_age == CMAX - 1) ns = M_MUTED;
      default: if (!any) ns = M_IDLE; else if (newf) ns = M_CHIME;
    endcase
    m_age   = (ns == m_state) ? m_age + 1 : 0;
    m_state = ns;
    m_alarm = (m_state == M_CHIME) && ((m_age / HALF) % 2 == 0);
    m_prev  = {m_door, m_belt};
    m_door  = Ignition && (m_filt[ND-1:0] != '1);
    m_belt  = {NS{Ignition}} & m_filt[ND+NS +: NS] & ~m_filt[ND +: NS];
    for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = {Occupied, SeatBelt, DoorClose};
    mask = '1;
    for (int k = 0; k < DEB; k++) mask &= m_hist[k] ^ m_filt;
    m_filt ^= mask;
  endtask

  task automatic tick(input string tag);
    logic [NS+3:0] obs, exp;
    @(posedge Clk);
    if (!RstN) model_reset(); else model_step();
    #1;
    obs = {State, Alarm, DoorWarn, BeltWarn};
    exp = {2'(m_state), m_alarm, m_door, m_belt};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int   n;
    logic seen;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    model_reset();
    repeat (2) tick("reset_hold");
    check("reset_state", 8'({State, Alarm, DoorWarn, BeltWarn}), 8'd0);
    RstN = 1'b1;
    Ignition = 1'b1;

    // Seat 1 occupied and unbelted: grace then chime
    Occupied[1] = 1'b1; SeatBelt[1] = 1'b0;
    repeat (3) tick("s2_debounce");
    check("s2_beltwarn", 8'(BeltWarn), 8'h2);
    check("s2_still_idle", 8'(State), 8'd0);
    n = 0;
    for (int i = 0; i < 20 && State != 2'd2; i++) begin
      tick("s2_grace");
      if (State == 2'd1) n++;
    end
    check("s2_grace_len", 8'(n), 8'd8);
    check("s2_first_alarm", 8'(Alarm), 8'd1);
    for (int i = 0; i < 4; i++) begin
      tick("s2_pattern");
      check("s2_alarm_pattern", 8'(Alarm), 8'(pat[i]));
    end
    SeatBelt[1] = 1'b1;
    repeat (4) tick("s2_fasten");
    check("s2_idle_after_fasten", 8'({State, Alarm}), 8'd0);

    // Door open: no grace, chime times out into MUTED
    DoorClose[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && State != 2'd2; i++) begin
      tick("s3_wait");
      if (State == 2'd1) seen = 1'b1;
    end
    check("s3_doorwarn", 8'(DoorWarn), 8'd1);
    check("s3_no_grace", 8'(seen), 8'd0);
    n = 1;
    for (int i = 0; i < 40 && State == 2'd2; i++) begin
      tick("s3_chime");
      if (State == 2'd2) n++;
    end
    check("s3_chime_len", 8'(n), 8'd16);
    check("s3_muted", 8'({State, Alarm, DoorWarn}), 8'b1101);

    // Ack mutes, a new belt fault re-arms
    DoorClose[2] = 1'b1;
    repeat (4) tick("s4_close");
    check("s4_idle", 8'(State), 8'd0);
    DoorClose[1] = 1'b0;
    for (int i = 0; i < 10 && State != 2'd2; i++) tick("s4_wait_chime");
    repeat (2) tick("s4_chime");
    Ack = 1'b1;
    tick("s4_ack");
    Ack = 1'b0;
    check("s4_muted", 8'(State), 8'd3);
    Occupied[0] = 1'b1; SeatBelt[0] = 1'b0;
    for (int i = 0; i < 10 && State != 2'd2; i++) tick("s4_wait_rearm");
    check("s4_rearm", 8'({State, Alarm}), 8'b101);

    // Ignition off clears everything on the next edge
    tick("s5_chime");
    Ignition = 1'b0;
    tick("s5_ign_off");
    check("s5_cleared", 8'({State, Alarm, DoorWarn, BeltWarn}), 8'd0);

    // Ack in the same cycle as the last fault clearing goes to IDLE
    SeatBelt[0] = 1'b1;
    repeat (3) tick("s6_fasten");
    Ignition = 1'b1;
    for (int i = 0; i < 10 && State != 2'd2; i++) tick("s6_wait_chime");
    DoorClose[1] = 1'b1;
    repeat (3) tick("s6_close");
    check("s6_pre_chime", 8'(State), 8'd2);
    Ack = 1'b1;
    tick("s6_ack_clear");
    Ack = 1'b0;
    check("s6_idle_not_muted", 8'(State), 8'd0);

    // Asynchronous reset in CHIME, then a short door glitch
    DoorClose[3] = 1'b0;
    for (int i = 0; i < 10 && State != 2'd2; i++) tick("s1_wait_chime");
    tick("s1_chime");
    #3;
    RstN = 1'b0;
    #1;
    model_reset();
    check("s1_async_reset", 8'({State, Alarm, DoorWarn, BeltWarn}), 8'd0);
    DoorClose = '1; SeatBelt = '1; Occupied = '0;
    repeat (2) tick("s1_reset_hold");
    RstN = 1'b1;
    DoorClose[0] = 1'b0;
    tick("s1_glitch");
    DoorClose[0] = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick("s1_after_glitch");
      if (DoorWarn) seen = 1'b1;
    end
    check("s1_glitch_filtered", 8'(seen), 8'd0);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(11) == 0) begin
        for (int b = 0; b < ND; b++) DoorClose[b] = ($urandom_range(3) != 0);
        for (int b = 0; b < NS; b++) begin
          Occupied[b] = ($urandom_range(1) != 0);
          SeatBelt[b] = ($urandom_range(1) != 0);
        end
      end
      Ignition = ($urandom_range(50) != 0);
      Ack      = ($urandom_range(15) == 0);
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
